// File: rtl/dip_switch_regs.sv
// Staged/active DIP-switch register file with a safe-point commit and an optional core reset pulse.
// State | meaning: IDLE = no commit outstanding; PENDING = waiting for apply_ok; APPLY = copy staged to active; HOLD = core_reset_req asserted.
module dip_switch_regs #(
  parameter int                         NUM_BANKS      = 2,
  parameter int                         DIP_W          = 20,
  parameter logic [31:0]                BASE_ADDR      = 32'hF000_0000,
  parameter logic [NUM_BANKS*DIP_W-1:0] DEFAULT        = '0,
  parameter bit                         RESET_ON_APPLY = 1'b1,
  parameter int                         RESET_CYCLES   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  bridge_addr,
  input  logic                         bridge_wr,
  input  logic [31:0]                  bridge_wr_data,
  input  logic                         bridge_rd,
  output logic [31:0]                  bridge_rd_data,
  input  logic                         apply_ok,
  output logic [NUM_BANKS*DIP_W-1:0]   dip_active,
  output logic                         dip_changed,
  output logic                         pending,
  output logic                         core_reset_req
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] APPLY   = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam int             CW        = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LOAD  = CW'(RESET_CYCLES);
  localparam logic [31:0]    CTRL_ADDR = BASE_ADDR + 32'(4 * NUM_BANKS);

  logic [1:0]                 state_q, state_d;
  logic [NUM_BANKS*DIP_W-1:0] staged_q, staged_d;
  logic [NUM_BANKS*DIP_W-1:0] active_q, active_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       rearm_q, rearm_d;
  logic                       changed_q;
  logic [31:0]                rd_data_q, rd_data_d;

  logic ctrl_hit, commit_wr, revert_wr, rearm_now;
  logic unused_wr_bits;

  assign unused_wr_bits = ^bridge_wr_data;

  assign ctrl_hit  = bridge_wr && (bridge_addr == CTRL_ADDR);
  // Revert wins over commit when both bits are written together.
  assign revert_wr = ctrl_hit && bridge_wr_data[1];
  assign commit_wr = ctrl_hit && bridge_wr_data[0] && !bridge_wr_data[1];
  assign rearm_now = rearm_q || (commit_wr && (state_q == APPLY || state_q == HOLD));

  always_comb begin
    staged_d = staged_q;
    if (revert_wr && state_q == IDLE) staged_d = active_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bridge_wr && bridge_addr == BASE_ADDR + 32'(4 * i))
        staged_d[i*DIP_W +: DIP_W] = bridge_wr_data[DIP_W-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    rearm_d  = rearm_q;
    case (state_q)
      IDLE:    if (commit_wr) state_d = PENDING;
      PENDING: if (apply_ok) state_d = APPLY;
      APPLY: begin
        active_d = staged_q;
        rearm_d  = rearm_now;
        if (RESET_ON_APPLY) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end else if (rearm_now) begin
          state_d = PENDING;
          rearm_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        rearm_d = rearm_now;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          if (rearm_now) begin
            state_d = PENDING;
            rearm_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    rd_data_d = '0;
    if (bridge_addr == CTRL_ADDR) rd_data_d = {29'b0, rearm_q, core_reset_req, pending};
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bridge_addr == BASE_ADDR + 32'(4 * i))
        rd_data_d = 32'(staged_q[i*DIP_W +: DIP_W]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      staged_q  <= DEFAULT;
      active_q  <= DEFAULT;
      cnt_q     <= '0;
      rearm_q   <= 1'b0;
      changed_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      staged_q  <= staged_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      rearm_q   <= rearm_d;
      changed_q <= (state_q == APPLY);
      if (bridge_rd) rd_data_q <= rd_data_d;
    end
  end

  assign bridge_rd_data = rd_data_q;
  assign dip_active     = active_q;
  assign dip_changed    = changed_q;
  assign pending        = (state_q == PENDING);
  assign core_reset_req = (state_q == HOLD);

endmodule

// File: tb/tb_dip_switch_regs.sv
// Directed bench for dip_switch_regs: reads and applies are checked by a scoreboard monitor.
module tb_dip_switch_regs;
  localparam int          NB   = 2;
  localparam int          DW   = 20;
  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam logic [31:0] CTRL = BASE + 32'd8;
  localparam logic [39:0] DEF  = 40'h00000_0A200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   bridge_addr = '0;
  logic          bridge_wr = 1'b0;
  logic [31:0]   bridge_wr_data = '0;
  logic          bridge_rd = 1'b0;
  logic [31:0]   bridge_rd_data;
  logic          apply_ok = 1'b0;
  logic [39:0]   dip_active;
  logic          dip_changed;
  logic          pending;
  logic          core_reset_req;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [39:0] act_exp_q[$];
  logic        rd_v = 1'b0;

  always #5 clk = ~clk;

  dip_switch_regs #(
    .NUM_BANKS(NB), .DIP_W(DW), .BASE_ADDR(BASE), .DEFAULT(DEF),
    .RESET_ON_APPLY(1'b1), .RESET_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
    .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
    .apply_ok(apply_ok), .dip_active(dip_active), .dip_changed(dip_changed),
    .pending(pending), .core_reset_req(core_reset_req)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_v <= bridge_rd;

  // Monitor: read data one cycle after a read strobe, active value on every dip_changed pulse.
  always @(negedge clk) begin
    if (rd_v) begin
      if (rd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %h expected no read", bridge_rd_data);
      end else begin
        chk(rd_name_q.pop_front(), 64'(bridge_rd_data), 64'(rd_exp_q.pop_front()));
      end
    end
    if (dip_changed) begin
      if (act_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL changed_unexpected: got pulse with active %h expected none", dip_active);
      end else begin
        chk("apply_value", 64'(dip_active), 64'(act_exp_q.pop_front()));
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
    @(negedge clk);
    bridge_wr = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] e);
    @(negedge clk);
    bridge_addr = a; bridge_rd = 1'b1;
    rd_exp_q.push_back(e); rd_name_q.push_back(nm);
    @(negedge clk);
    bridge_rd = 1'b0;
  endtask

  task automatic rdwr(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    @(negedge clk);
    bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1; bridge_rd = 1'b1;
    rd_exp_q.push_back(e); rd_name_q.push_back(nm);
    @(negedge clk);
    bridge_wr = 1'b0; bridge_rd = 1'b0;
  endtask

  // Raise apply_ok from PENDING and return on the cycle the new active value is visible.
  task automatic do_apply(input logic [39:0] e);
    apply_ok = 1'b1;
    act_exp_q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    apply_ok = 1'b0;
  endtask

  task automatic wait_hold(output int n);
    n = 0;
    while (core_reset_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL hold_timeout: got %0d cycles expected release", n);
    end
  endtask

  initial begin
    int n;
    logic bad;
    #1;
    chk("reset_rd_data", 64'(bridge_rd_data), 64'h0);
    chk("reset_req_async", 64'(core_reset_req), 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset image
    chk("reset_active", 64'(dip_active), 64'(DEF));
    chk("reset_pending", 64'(pending), 64'h0);
    chk("reset_changed", 64'(dip_changed), 64'h0);
    rd("rd_bank0_def", BASE, 32'h0000_A200);
    rd("rd_bank1_def", BASE + 4, 32'h0);
    rd("rd_ctrl_def", CTRL, 32'h0);

    // 2: bank write truncation, read-before-write on a same-cycle collision
    wr(BASE + 4, 32'hFFFF_FFFF);
    rd("rd_bank1_trunc", BASE + 4, 32'h000F_FFFF);
    chk("active_untouched", 64'(dip_active), 64'(DEF));
    rdwr("rd_wr_collide", BASE + 4, 32'h0001_2345, 32'h000F_FFFF);
    rd("rd_after_collide", BASE + 4, 32'h0001_2345);
    wr(BASE + 4, 32'hFFFF_FFFF);

    // 3: commit waits for apply_ok, then apply and 16-cycle reset hold
    wr(CTRL, 32'h1);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!pending || dip_active !== DEF) bad = 1'b1;
    end
    chk("pending_hold50", 64'(bad), 64'h0);
    apply_ok = 1'b1;
    act_exp_q.push_back({20'hFFFFF, 20'h0A200});
    @(negedge clk);
    chk("active_before_apply", 64'(dip_active), 64'(DEF));
    chk("pending_in_apply", 64'(pending), 64'h0);
    @(negedge clk);
    apply_ok = 1'b0;
    chk("active_after_apply", 64'(dip_active), 64'({20'hFFFFF, 20'h0A200}));
    wait_hold(n);
    chk("hold_length", 64'(n), 64'd16);
    chk("pending_after_hold", 64'(pending), 64'h0);

    // 4: commit during HOLD sets rearm and re-enters PENDING
    wr(CTRL, 32'h1);
    do_apply({20'hFFFFF, 20'h0A200});
    wr(BASE, 32'h1);
    wr(CTRL, 32'h1);
    rd("rd_ctrl_rearm", CTRL, 32'h6);
    rd("rd_bank0_staged", BASE, 32'h1);
    chk("active_in_hold", 64'(dip_active), 64'({20'hFFFFF, 20'h0A200}));
    wait_hold(n);
    chk("rearm_to_pending", 64'(pending), 64'h1);
    rd("rd_ctrl_pending", CTRL, 32'h1);
    do_apply({20'hFFFFF, 20'h00001});
    wait_hold(n);
    chk("idle_after_rearm", 64'(pending), 64'h0);
    rd("rd_ctrl_idle", CTRL, 32'h0);

    // 5: revert in IDLE, ignored in PENDING
    wr(BASE, 32'h5);
    rd("rd_bank0_stage5", BASE, 32'h5);
    wr(CTRL, 32'h2);
    rd("rd_revert_idle", BASE, 32'h1);
    wr(BASE, 32'h5);
    wr(CTRL, 32'h1);
    chk("pending_again", 64'(pending), 64'h1);
    wr(CTRL, 32'h2);
    rd("rd_revert_ignored", BASE, 32'h5);
    rd("rd_ctrl_still_pend", CTRL, 32'h1);

    // 6: async reset in cycle 5 of HOLD
    do_apply({20'hFFFFF, 20'h00005});
    repeat (4) @(negedge clk);
    chk("hold_cycle5", 64'(core_reset_req), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("reset_drops_req", 64'(core_reset_req), 64'h0);
    chk("reset_mid_active", 64'(dip_active), 64'(DEF));
    chk("reset_mid_pending", 64'(pending), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    rd("rd_bank0_lost", BASE, 32'h0000_A200);
    rd("rd_bank1_lost", BASE + 4, 32'h0);
    rd("rd_ctrl_reset", CTRL, 32'h0);
    wr(CTRL + 4, 32'hFFFF_FFFF);
    rd("rd_unmapped", CTRL + 4, 32'h0);
    rd("rd_bank0_unmapped", BASE, 32'h0000_A200);
    rd("rd_bank1_unmapped", BASE + 4, 32'h0);
    chk("unmapped_pending", 64'(pending), 64'h0);

    // both control bits: revert wins, no commit
    wr(BASE, 32'h7);
    wr(CTRL, 32'h3);
    chk("both_bits_no_commit", 64'(pending), 64'h0);
    rd("rd_both_bits_revert", BASE, 32'h0000_A200);

    repeat (3) @(negedge clk);
    chk("rd_queue_drained", 64'(rd_exp_q.size()), 64'h0);
    chk("apply_queue_drained", 64'(act_exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
